// File: rtl/frame_pad.sv
// Frame padder: surrounds each frame of the vector stream with a programmable
// number of leading/trailing pad vectors (zero or edge-replicated).
module frame_pad #(
    parameter  int BW         = 8,
    parameter  int VECTOR_LEN = 13,
    parameter  int CNT_BW     = 3,
    localparam int VECTOR_BW  = BW * VECTOR_LEN
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CNT_BW-1:0]    pre_cnt_i,
    input  logic [CNT_BW-1:0]    post_cnt_i,
    input  logic                 mode_i,
    input  logic [VECTOR_BW-1:0] data_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    output logic                 ready_o,
    output logic [VECTOR_BW-1:0] data_o,
    output logic                 valid_o,
    output logic                 last_o,
    input  logic                 ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        BODY,
        POST
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_BW-1:0]     cnt_q, cnt_d;
    logic [CNT_BW-1:0]     post_q, post_d;
    logic                  mode_q, mode_d;
    logic [VECTOR_BW-1:0]  last_buf_q, last_buf_d;

    logic                  out_en;
    logic                  body_beat;
    logic                  pre_zero;
    logic [CNT_BW-1:0]     eff_post;
    logic                  eff_mode;
    logic [VECTOR_BW-1:0]  pad_lead;
    logic [VECTOR_BW-1:0]  pad_trail;

    logic                  emit;
    logic                  emit_last;
    logic [VECTOR_BW-1:0]  emit_data;

    // Output stage is free when empty or being drained this cycle.
    assign out_en   = !valid_o || ready_i;
    assign pre_zero = (pre_cnt_i == '0);

    assign ready_o   = out_en && !rst_i && (state_q == BODY || (state_q == IDLE && pre_zero));
    assign body_beat = valid_i && ready_o;

    // In IDLE the config is being latched this very cycle, so use it directly.
    assign eff_post = (state_q == IDLE) ? post_cnt_i : post_q;
    assign eff_mode = (state_q == IDLE) ? mode_i : mode_q;

    // Leading pads replicate the first vector, which is held on data_i until accepted.
    assign pad_lead  = eff_mode ? data_i : '0;
    assign pad_trail = mode_q ? last_buf_q : '0;

    // State register and frame context.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            post_q     <= '0;
            mode_q     <= 1'b0;
            last_buf_q <= '0;
        end else begin
            // NOTE: all sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            post_q     <= post_d;
            mode_q     <= mode_d;
            last_buf_q <= last_buf_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        post_d     = post_q;
        mode_d     = mode_q;
        last_buf_d = last_buf_q;

        if (out_en) begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        post_d = post_cnt_i;
                        mode_d = mode_i;
                        if (!pre_zero) begin
                            cnt_d   = pre_cnt_i - 1'b1;
                            state_d = (pre_cnt_i == CNT_BW'(1)) ? BODY : PRE;
                        end
                    end
                end
                PRE: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_BW'(1)) begin
                        state_d = BODY;
                    end
                end
                BODY: begin
                end
                POST: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_BW'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Accepted body beats share one path whether they come from IDLE or BODY.
        if (body_beat) begin
            last_buf_d = data_i;
            if (!last_i) begin
                state_d = BODY;
            end else if (eff_post == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d   = eff_post;
                state_d = POST;
            end
        end
    end

    // Output decode: what the output register would load if it is free.
    always_comb begin
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_data = '0;

        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    emit      = 1'b1;
                    emit_data = pre_zero ? data_i : pad_lead;
                    emit_last = pre_zero && last_i && (post_cnt_i == '0);
                end
            end
            PRE: begin
                emit      = 1'b1;
                emit_data = pad_lead;
            end
            BODY: begin
                if (valid_i) begin
                    emit      = 1'b1;
                    emit_data = data_i;
                    emit_last = last_i && (post_q == '0);
                end
            end
            POST: begin
                emit      = 1'b1;
                emit_data = pad_trail;
                emit_last = (cnt_q == CNT_BW'(1));
            end
            default: begin
            end
        endcase
    end

    // Registered output stage; holds while the downstream stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the wide data registers are reset too, because data_o must
            // read as zero straight out of reset.
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            data_o  <= '0;
        end else if (out_en) begin
            valid_o <= emit;
            last_o  <= emit_last;
            if (emit) begin
                data_o <= emit_data;
            end
        end
    end

endmodule

// File: tb/tb_frame_pad.sv
// Self-checking bench for frame_pad: directed vector table plus a randomised
// backpressure run checked against a scoreboard of expected padded beats.
module tb_frame_pad;

    localparam int BW   = 8;
    localparam int VLEN = 13;
    localparam int VBW  = BW * VLEN;
    localparam int CBW  = 3;

    logic           clk_i;
    logic           rst_i;
    logic [CBW-1:0] pre_cnt_i;
    logic [CBW-1:0] post_cnt_i;
    logic           mode_i;
    logic [VBW-1:0] data_i;
    logic           valid_i;
    logic           last_i;
    logic           ready_o;
    logic [VBW-1:0] data_o;
    logic           valid_o;
    logic           last_o;
    logic           ready_i;

    frame_pad #(
        .BW        (BW),
        .VECTOR_LEN(VLEN),
        .CNT_BW    (CBW)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .pre_cnt_i (pre_cnt_i),
        .post_cnt_i(post_cnt_i),
        .mode_i    (mode_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .last_i    (last_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .last_o    (last_o),
        .ready_i   (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic           rst;
        logic [CBW-1:0] pre;
        logic [CBW-1:0] post;
        logic           mode;
        logic [VBW-1:0] data;
        logic           valid;
        logic           last;
        logic           rdy;
        logic           e_ready;
        logic           e_valid;
        logic [VBW-1:0] e_data;
        logic           e_last;
    } vec_t;

    typedef struct {
        logic [VBW-1:0] d;
        logic           l;
    } beat_t;

    vec_t  vecs[$];
    beat_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_last  = 0;
    bit rnd_on  = 1'b0;

    task automatic check(input string name, input logic [VBW-1:0] act, input logic [VBW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VBW-1:0] mk(input int s);
        logic [VBW-1:0] v;
        for (int i = 0; i < VLEN; i++) begin
            v[i*BW +: BW] = BW'(s * 17 + i * 3 + 1);
        end
        return v;
    endfunction

    function automatic void add(input logic rst, input logic [CBW-1:0] pre, input logic [CBW-1:0] post,
                                input logic mode, input logic [VBW-1:0] data, input logic valid,
                                input logic last, input logic rdy, input logic e_ready,
                                input logic e_valid, input logic [VBW-1:0] e_data, input logic e_last);
        vec_t v;
        v.rst = rst;   v.pre = pre;   v.post = post;   v.mode = mode;
        v.data = data; v.valid = valid; v.last = last; v.rdy = rdy;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_data = e_data; v.e_last = e_last;
        vecs.push_back(v);
    endfunction

    task automatic send_beat(input logic [VBW-1:0] d, input logic l, input logic m);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        mode_i  = m;
        while (!acc && n < 200) begin
            #4;
            acc = ready_o;
            @(posedge clk_i);
            if (!acc) begin
                @(negedge clk_i);
                n++;
            end
        end
        check("accept", acc, 1'b1);
    endtask

    task automatic ready_gen();
        while (rnd_on) begin
            @(negedge clk_i);
            ready_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic monitor();
        logic           prev_stall;
        logic [VBW-1:0] prev_d;
        logic           prev_l;
        beat_t          b;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        while (rnd_on) begin
            @(negedge clk_i);
            #4;
            if (prev_stall) begin
                check("hold valid", valid_o, 1'b1);
                check("hold data", data_o, prev_d);
                check("hold last", last_o, prev_l);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra beat: got %h, expected none", data_o);
                end else begin
                    b = exp_q.pop_front();
                    check("rnd data", data_o, b.d);
                    check("rnd last", last_o, b.l);
                end
                if (last_o) n_last++;
            end
            prev_stall = valid_o && !ready_i;
            prev_d     = data_o;
            prev_l     = last_o;
        end
    endtask

    initial begin
        logic [VBW-1:0] a, b, c, x, y, d0, d1, d2, e, z;
        logic [VBW-1:0] fr[8];
        int             len;
        logic           m;
        int             w;

        rst_i = 1'b1; pre_cnt_i = '0; post_cnt_i = '0; mode_i = 1'b0;
        data_i = '0;  valid_i = 1'b0; last_i = 1'b0;   ready_i = 1'b1;

        a = mk(1); b = mk(2); c = mk(3); x = mk(4); y = mk(5);
        d0 = mk(6); d1 = mk(7); d2 = mk(8); e = mk(9); z = '0;

        // rst pre post mode data valid last rdy | ready valid data last
        add(1, 0, 0, 0, z, 0, 0, 1,  0, 0, z, 0);
        add(1, 0, 0, 0, z, 0, 0, 1,  0, 0, z, 0);
        // 1+1 zero pad around A,B,C
        add(0, 1, 1, 0, a, 1, 0, 1,  0, 1, z, 0);
        add(0, 1, 1, 0, a, 1, 0, 1,  1, 1, a, 0);
        add(0, 1, 1, 0, b, 1, 0, 1,  1, 1, b, 0);
        add(0, 1, 1, 0, c, 1, 1, 1,  1, 1, c, 0);
        add(0, 1, 1, 0, z, 0, 0, 1,  0, 1, z, 1);
        add(0, 1, 1, 0, z, 0, 0, 1,  0, 0, z, 0);
        // 2+3 edge replicate; config inputs change mid-frame and must be ignored
        add(0, 2, 3, 1, a, 1, 0, 1,  0, 1, a, 0);
        add(0, 2, 3, 1, a, 1, 0, 1,  0, 1, a, 0);
        add(0, 2, 3, 1, a, 1, 0, 1,  1, 1, a, 0);
        add(0, 2, 3, 1, b, 1, 1, 1,  1, 1, b, 0);
        add(0, 0, 0, 0, z, 0, 0, 1,  0, 1, b, 0);
        add(0, 0, 0, 0, z, 0, 0, 1,  0, 1, b, 0);
        add(0, 0, 0, 0, z, 0, 0, 1,  0, 1, b, 1);
        add(0, 0, 0, 0, z, 0, 0, 1,  1, 0, z, 0);
        // pass-through with a downstream stall
        add(0, 0, 0, 0, a, 1, 0, 1,  1, 1, a, 0);
        add(0, 0, 0, 0, b, 1, 0, 0,  0, 1, a, 0);
        add(0, 0, 0, 0, b, 1, 0, 1,  1, 1, b, 0);
        add(0, 0, 0, 0, c, 1, 1, 1,  1, 1, c, 1);
        add(0, 0, 0, 0, z, 0, 0, 1,  1, 0, z, 0);
        // back-to-back single-vector frames X, Y
        add(0, 1, 1, 0, x, 1, 1, 1,  0, 1, z, 0);
        add(0, 1, 1, 0, x, 1, 1, 1,  1, 1, x, 0);
        add(0, 1, 1, 0, y, 1, 1, 1,  0, 1, z, 1);
        add(0, 1, 1, 0, y, 1, 1, 1,  0, 1, z, 0);
        add(0, 1, 1, 0, y, 1, 1, 1,  1, 1, y, 0);
        add(0, 1, 1, 0, z, 0, 0, 1,  0, 1, z, 1);
        add(0, 1, 1, 0, z, 0, 0, 1,  0, 0, z, 0);
        // reset mid-body, then a fresh frame
        add(0, 1, 1, 0, d0, 1, 0, 1, 0, 1, z, 0);
        add(0, 1, 1, 0, d0, 1, 0, 1, 1, 1, d0, 0);
        add(0, 1, 1, 0, d1, 1, 0, 1, 1, 1, d1, 0);
        add(1, 1, 1, 0, d2, 1, 0, 1, 0, 0, z, 0);
        add(0, 1, 1, 0, e, 1, 1, 1,  0, 1, z, 0);
        add(0, 1, 1, 0, e, 1, 1, 1,  1, 1, e, 0);
        add(0, 1, 1, 0, z, 0, 0, 1,  0, 1, z, 1);
        add(0, 1, 1, 0, z, 0, 0, 1,  0, 0, z, 0);

        foreach (vecs[i]) begin
            @(negedge clk_i);
            rst_i = vecs[i].rst;   pre_cnt_i = vecs[i].pre; post_cnt_i = vecs[i].post;
            mode_i = vecs[i].mode; data_i = vecs[i].data;   valid_i = vecs[i].valid;
            last_i = vecs[i].last; ready_i = vecs[i].rdy;
            #1;
            check($sformatf("v%0d ready_o", i), ready_o, vecs[i].e_ready);
            @(posedge clk_i);
            #1;
            check($sformatf("v%0d valid_o", i), valid_o, vecs[i].e_valid);
            check($sformatf("v%0d last_o", i), last_o, vecs[i].e_last);
            if (vecs[i].e_valid || vecs[i].rst) begin
                check($sformatf("v%0d data_o", i), data_o, vecs[i].e_data);
            end
        end

        // Random backpressure: 20 frames of length 1..8 with pre=post=1.
        @(negedge clk_i);
        rst_i = 1'b0; pre_cnt_i = 3'd1; post_cnt_i = 3'd1; valid_i = 1'b0; last_i = 1'b0;
        rnd_on = 1'b1;
        fork
            ready_gen();
            monitor();
        join_none

        for (int f = 0; f < 20; f++) begin
            len = int'($urandom_range(1, 8));
            m   = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) fr[k] = mk(100 + f * 8 + k);
            exp_q.push_back('{m ? fr[0] : '0, 1'b0});
            for (int k = 0; k < len; k++) exp_q.push_back('{fr[k], 1'b0});
            exp_q.push_back('{m ? fr[len-1] : '0, 1'b1});
            for (int k = 0; k < len; k++) begin
                if (k > 0 && $urandom_range(0, 3) == 0) begin
                    @(negedge clk_i);
                    valid_i = 1'b0;
                end
                send_beat(fr[k], (k == len - 1), m);
            end
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        last_i  = 1'b0;

        w = 0;
        while (exp_q.size() > 0 && w < 500) begin
            @(posedge clk_i);
            w++;
        end
        repeat (3) @(posedge clk_i);
        rnd_on = 1'b0;
        repeat (2) @(posedge clk_i);
        ready_i = 1'b1;

        check("drain", exp_q.size(), 0);
        check("last count", n_last, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
